score_keeper: RTL and testbench

//  Pong match scorer: turns goal events into two-digit BCD scores per player and runs the match

---
 rtl/score_keeper_pkg.sv | 25 ++
 rtl/score_keeper_bcd_counter_2d.sv | 32 +++
 rtl/score_keeper.sv | 158 +++++++++++++++
 tb/tb_score_keeper.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/score_keeper_pkg.sv
// Shared definitions for the Pong score keeper: match states, winner codes and BCD helpers.
package score_keeper_pkg;

  localparam int unsigned CLK_HZ  = 50_000_000;
  localparam int unsigned DIGIT_W = 4;
  localparam int unsigned BIN_W   = 8;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_PLAY      = 2'd1,
    ST_PAUSE     = 2'd2,
    ST_GAME_OVER = 2'd3
  } state_t;

  localparam logic [1:0] WIN_NONE  = 2'b00;
  localparam logic [1:0] WIN_LEFT  = 2'b01;
  localparam logic [1:0] WIN_RIGHT = 2'b10;

  // Binary value of a two-digit BCD score.
  function automatic logic [BIN_W-1:0] bcd_to_bin(input logic [DIGIT_W-1:0] tens,
                                                  input logic [DIGIT_W-1:0] ones);
    return BIN_W'(BIN_W'(tens) * BIN_W'(10) + BIN_W'(ones));
  endfunction

endpackage

// File: rtl/score_keeper_bcd_counter_2d.sv
// Two-digit BCD up-counter with synchronous clear (clear wins over increment).
module score_keeper_bcd_counter_2d
  import score_keeper_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clr,
  input  logic               inc,
  output logic [DIGIT_W-1:0] ones,
  output logic [DIGIT_W-1:0] tens
);

  localparam logic [DIGIT_W-1:0] DIGIT_MAX = DIGIT_W'(9);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ones <= '0;
      tens <= '0;
    end else if (clr) begin
      ones <= '0;
      tens <= '0;
    end else if (inc) begin
      if (ones == DIGIT_MAX) begin
        ones <= '0;
        tens <= (tens == DIGIT_MAX) ? '0 : tens + DIGIT_W'(1);
      end else begin
        ones <= ones + DIGIT_W'(1);
      end
    end
  end

endmodule

// File: rtl/score_keeper.sv
// Pong match scorer: goal edge detection, match FSM, serve pause timer and win detection.
module score_keeper
  import score_keeper_pkg::*;
#(
  parameter int unsigned WIN_SCORE    = 11,
  parameter int unsigned PAUSE_CYCLES = CLK_HZ
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               goal_left,
  input  logic               goal_right,
  input  logic               new_game,
  output logic [DIGIT_W-1:0] score_l_ones,
  output logic [DIGIT_W-1:0] score_l_tens,
  output logic [DIGIT_W-1:0] score_r_ones,
  output logic [DIGIT_W-1:0] score_r_tens,
  output logic               serve_en,
  output logic               game_over,
  output logic [1:0]         winner
);

  localparam int unsigned        CNT_W      = $clog2(PAUSE_CYCLES + 1);
  localparam logic [CNT_W-1:0]   CNT_RELOAD = CNT_W'(PAUSE_CYCLES - 1);
  localparam logic [BIN_W-1:0]   WIN_BIN    = BIN_W'(WIN_SCORE);

  logic goal_left_q, goal_right_q, new_game_q;
  logic goal_left_rise_c, goal_right_rise_c, new_game_rise_c;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             serve_en_d, game_over_d;
  logic [1:0]       winner_d;
  logic             clr_c, inc_l_c, inc_r_c;
  logic [BIN_W-1:0] next_l_bin_c, next_r_bin_c;

  // Rising-edge detectors; zeroed history makes a level high at reset release count once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      goal_left_q  <= 1'b0;
      goal_right_q <= 1'b0;
      new_game_q   <= 1'b0;
    end else begin
      goal_left_q  <= goal_left;
      goal_right_q <= goal_right;
      new_game_q   <= new_game;
    end
  end

  assign goal_left_rise_c  = goal_left  & ~goal_left_q;
  assign goal_right_rise_c = goal_right & ~goal_right_q;
  assign new_game_rise_c   = new_game   & ~new_game_q;

  // Score after a prospective increment, compared in binary against WIN_SCORE.
  assign next_l_bin_c = bcd_to_bin(score_l_tens, score_l_ones) + BIN_W'(1);
  assign next_r_bin_c = bcd_to_bin(score_r_tens, score_r_ones) + BIN_W'(1);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    serve_en_d  = serve_en;
    game_over_d = game_over;
    winner_d    = winner;
    clr_c       = 1'b0;
    inc_l_c     = 1'b0;
    inc_r_c     = 1'b0;

    if (new_game_rise_c) begin
      state_d     = ST_PAUSE;
      cnt_d       = CNT_RELOAD;
      clr_c       = 1'b1;
      serve_en_d  = 1'b0;
      game_over_d = 1'b0;
      winner_d    = WIN_NONE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          serve_en_d = 1'b0;
        end
        ST_PLAY: begin
          if (goal_left_rise_c && goal_right_rise_c) begin
            state_d    = ST_PAUSE;
            cnt_d      = CNT_RELOAD;
            serve_en_d = 1'b0;
          end else if (goal_right_rise_c) begin
            inc_l_c    = 1'b1;
            serve_en_d = 1'b0;
            if (next_l_bin_c == WIN_BIN) begin
              state_d     = ST_GAME_OVER;
              game_over_d = 1'b1;
              winner_d    = WIN_LEFT;
            end else begin
              state_d = ST_PAUSE;
              cnt_d   = CNT_RELOAD;
            end
          end else if (goal_left_rise_c) begin
            inc_r_c    = 1'b1;
            serve_en_d = 1'b0;
            if (next_r_bin_c == WIN_BIN) begin
              state_d     = ST_GAME_OVER;
              game_over_d = 1'b1;
              winner_d    = WIN_RIGHT;
            end else begin
              state_d = ST_PAUSE;
              cnt_d   = CNT_RELOAD;
            end
          end
        end
        ST_PAUSE: begin
          if (cnt_q == '0) begin
            state_d    = ST_PLAY;
            serve_en_d = 1'b1;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        ST_GAME_OVER: begin
          serve_en_d  = 1'b0;
          game_over_d = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      serve_en  <= 1'b0;
      game_over <= 1'b0;
      winner    <= WIN_NONE;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      serve_en  <= serve_en_d;
      game_over <= game_over_d;
      winner    <= winner_d;
    end
  end

  score_keeper_bcd_counter_2d u_score_l (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr_c),
    .inc   (inc_l_c),
    .ones  (score_l_ones),
    .tens  (score_l_tens)
  );

  score_keeper_bcd_counter_2d u_score_r (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr_c),
    .inc   (inc_r_c),
    .ones  (score_r_ones),
    .tens  (score_r_tens)
  );

endmodule

// File: tb/tb_score_keeper.sv
// Directed bench for score_keeper with PAUSE_CYCLES=4, WIN_SCORE=11.
module tb_score_keeper;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       goal_left, goal_right, new_game;
  logic [3:0] score_l_ones, score_l_tens, score_r_ones, score_r_tens;
  logic       serve_en, game_over;
  logic [1:0] winner;

  int checks   = 0;
  int failures = 0;

  score_keeper #(.WIN_SCORE(11), .PAUSE_CYCLES(4)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .goal_left    (goal_left),
    .goal_right   (goal_right),
    .new_game     (new_game),
    .score_l_ones (score_l_ones),
    .score_l_tens (score_l_tens),
    .score_r_ones (score_r_ones),
    .score_r_tens (score_r_tens),
    .serve_en     (serve_en),
    .game_over    (game_over),
    .winner       (winner)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_scores(input string tag, input int l, input int r);
    chk({tag, "_l_tens"}, 8'(score_l_tens), 8'(l / 10));
    chk({tag, "_l_ones"}, 8'(score_l_ones), 8'(l % 10));
    chk({tag, "_r_tens"}, 8'(score_r_tens), 8'(r / 10));
    chk({tag, "_r_ones"}, 8'(score_r_ones), 8'(r % 10));
  endtask

  // One-cycle goal pulse, then wait out the 4-cycle pause; returns in PLAY.
  task automatic point_left_player();
    @(negedge clk); goal_right = 1'b1;
    @(negedge clk); goal_right = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic point_right_player();
    @(negedge clk); goal_left = 1'b1;
    @(negedge clk); goal_left = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic start_game();
    @(negedge clk); new_game = 1'b1;
    @(negedge clk); new_game = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0; goal_left = 1'b0; goal_right = 1'b0; new_game = 1'b0;
    repeat (3) @(negedge clk);
    chk_scores("reset", 0, 0);
    chk("reset_serve", 8'(serve_en), 8'd0);
    chk("reset_game_over", 8'(game_over), 8'd0);
    chk("reset_winner", 8'(winner), 8'd0);
    rst_n = 1'b1;

    // Goals in IDLE are ignored
    @(negedge clk); goal_right = 1'b1;
    @(negedge clk); goal_right = 1'b0;
    @(negedge clk);
    chk_scores("idle_goal", 0, 0);
    chk("idle_serve", 8'(serve_en), 8'd0);

    // 1. new_game: serve low for 4 cycles then high
    @(negedge clk); new_game = 1'b1;
    @(negedge clk); new_game = 1'b0;
    chk("t1_serve_p1", 8'(serve_en), 8'd0);
    repeat (3) begin
      @(negedge clk);
      chk("t1_serve_pause", 8'(serve_en), 8'd0);
    end
    @(negedge clk);
    chk("t1_serve_play", 8'(serve_en), 8'd1);
    chk_scores("t1", 0, 0);
    chk("t1_winner", 8'(winner), 8'd0);

    // 2. Held goal_right counts once
    @(negedge clk); goal_right = 1'b1;
    @(negedge clk);
    chk_scores("t2_first", 1, 0);
    chk("t2_serve_p1", 8'(serve_en), 8'd0);
    repeat (3) begin
      @(negedge clk);
      chk("t2_serve_pause", 8'(serve_en), 8'd0);
    end
    @(negedge clk);
    chk("t2_serve_play", 8'(serve_en), 8'd1);
    repeat (5) @(negedge clk);
    chk_scores("t2_held", 1, 0);
    chk("t2_serve_held", 8'(serve_en), 8'd1);
    goal_right = 1'b0;

    // 3. Left player walks to 11 through the 9 -> 10 carry
    for (int i = 2; i <= 11; i++) begin
      point_left_player();
      if (i == 9)  chk_scores("t3_nine", 9, 0);
      if (i == 10) chk_scores("t3_ten", 10, 0);
    end
    chk_scores("t3_win", 11, 0);
    chk("t3_game_over", 8'(game_over), 8'd1);
    chk("t3_winner", 8'(winner), 8'd1);
    chk("t3_serve", 8'(serve_en), 8'd0);

    // 5. Goals in GAME_OVER are ignored; new_game restarts
    point_left_player();
    point_right_player();
    chk_scores("t5_go_goals", 11, 0);
    chk("t5_go_held", 8'(game_over), 8'd1);
    @(negedge clk); new_game = 1'b1;
    @(negedge clk); new_game = 1'b0;
    chk_scores("t5_restart", 0, 0);
    chk("t5_winner", 8'(winner), 8'd0);
    chk("t5_game_over", 8'(game_over), 8'd0);
    chk("t5_serve_pause", 8'(serve_en), 8'd0);
    repeat (4) @(negedge clk);
    chk("t5_serve_play", 8'(serve_en), 8'd1);

    // 4. Simultaneous goals: no score, replayed serve; goals in PAUSE ignored
    point_right_player();
    chk_scores("t4_pre", 0, 1);
    @(negedge clk); goal_left = 1'b1; goal_right = 1'b1;
    @(negedge clk); goal_left = 1'b0; goal_right = 1'b0;
    chk_scores("t4_both", 0, 1);
    chk("t4_serve_p1", 8'(serve_en), 8'd0);
    goal_right = 1'b1;
    @(negedge clk); goal_right = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("t4_serve_p4", 8'(serve_en), 8'd0);
    @(negedge clk);
    chk("t4_serve_play", 8'(serve_en), 8'd1);
    chk_scores("t4_pause_goal", 0, 1);

    // 6. Async reset mid-PAUSE with scores 3-7
    repeat (3) point_left_player();
    repeat (5) point_right_player();
    @(negedge clk); goal_left = 1'b1;
    @(negedge clk); goal_left = 1'b0;
    chk_scores("t6_pre", 3, 7);
    chk("t6_pre_serve", 8'(serve_en), 8'd0);
    #2 rst_n = 1'b0;
    #1;
    chk_scores("t6_async", 0, 0);
    chk("t6_serve", 8'(serve_en), 8'd0);
    chk("t6_game_over", 8'(game_over), 8'd0);
    chk("t6_winner", 8'(winner), 8'd0);
    @(negedge clk); rst_n = 1'b1;
    repeat (6) @(negedge clk);
    chk("t6_idle_after", 8'(serve_en), 8'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
